// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single memory port shared by the core and the program loader.
// Latency: issue one cycle after a request is seen in IDLE; ack 1 cycle (write) or MEM_LATENCY+1 cycles (read) after issue.
// Backpressure: requests are held until ack; a request is only sampled in IDLE, so one transaction is in flight at a time.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    output logic                  ldr_ack,
    output logic [DATA_WIDTH-1:0] ldr_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  owner
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic                  last_owner, last_owner_nxt;
    logic                  owner_nxt, busy_nxt;
    logic                  cpu_ack_nxt, ldr_ack_nxt;
    logic [DATA_WIDTH-1:0] cpu_rdata_nxt, ldr_rdata_nxt;
    logic                  mem_en_nxt, mem_we_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt;
    logic [DATA_WIDTH-1:0] mem_wdata_nxt;
    logic                  grant_ldr;

    // On a tie the loader wins only if the core had the previous grant.
    assign grant_ldr = ldr_req && (!cpu_req || !last_owner);

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_owner_nxt = last_owner;
        owner_nxt      = owner;
        busy_nxt       = busy;
        cpu_ack_nxt    = 1'b0;
        ldr_ack_nxt    = 1'b0;
        cpu_rdata_nxt  = cpu_rdata;
        ldr_rdata_nxt  = ldr_rdata;
        mem_en_nxt     = 1'b0;
        mem_we_nxt     = 1'b0;
        mem_addr_nxt   = '0;
        mem_wdata_nxt  = '0;

        case (state)
            IDLE: begin
                if (cpu_req || ldr_req) begin
                    owner_nxt      = grant_ldr;
                    last_owner_nxt = grant_ldr;
                    busy_nxt       = 1'b1;
                    mem_en_nxt     = 1'b1;
                    mem_we_nxt     = grant_ldr ? ldr_we   : cpu_we;
                    mem_addr_nxt   = grant_ldr ? ldr_addr : cpu_addr;
                    if (mem_we_nxt) begin
                        mem_wdata_nxt = grant_ldr ? ldr_wdata : cpu_wdata;
                    end
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // mem_we still holds the latched direction during the issue cycle.
                if (mem_we) begin
                    cpu_ack_nxt = !owner;
                    ldr_ack_nxt = owner;
                    state_nxt   = ACK;
                end else begin
                    cnt_nxt   = LAT;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    if (owner) begin
                        ldr_rdata_nxt = mem_rdata;
                        ldr_ack_nxt   = 1'b1;
                    end else begin
                        cpu_rdata_nxt = mem_rdata;
                        cpu_ack_nxt   = 1'b1;
                    end
                    state_nxt = ACK;
                end
            end
            ACK: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_owner <= 1'b1;
            owner      <= 1'b0;
            busy       <= 1'b0;
            cpu_ack    <= 1'b0;
            ldr_ack    <= 1'b0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_owner <= last_owner_nxt;
            owner      <= owner_nxt;
            busy       <= busy_nxt;
            cpu_ack    <= cpu_ack_nxt;
            ldr_ack    <= ldr_ack_nxt;
            cpu_rdata  <= cpu_rdata_nxt;
            ldr_rdata  <= ldr_rdata_nxt;
            mem_en     <= mem_en_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus hand sequences for
// contention, late arrival and reset during a read.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        ldr_req, ldr_we, ldr_ack;
    logic [15:0] ldr_addr;
    logic [31:0] ldr_wdata, ldr_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        busy, owner;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Inputs of a row are driven during one cycle; expected values are the outputs after the edge that samples them.
    typedef struct {
        logic        rst, c_req, c_we;
        logic [15:0] c_addr;
        logic [31:0] c_wd;
        logic        l_req, l_we;
        logic [15:0] l_addr;
        logic [31:0] l_wd, mrd;
        logic        e_cack, e_lack;
        logic [31:0] e_crd, e_lrd;
        logic        e_en, e_we;
        logic [15:0] e_addr;
        logic [31:0] e_wd;
        logic        e_busy, e_owner;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        reset = v.rst;
        cpu_req = v.c_req; cpu_we = v.c_we; cpu_addr = v.c_addr; cpu_wdata = v.c_wd;
        ldr_req = v.l_req; ldr_we = v.l_we; ldr_addr = v.l_addr; ldr_wdata = v.l_wd;
        mem_rdata = v.mrd;
    endtask

    task automatic core_read(input logic [15:0] a, input logic [31:0] d);
        for (int i = 0; i < 6; i++) begin
            cpu_req = (i < 2); cpu_we = 1'b0; cpu_addr = a; cpu_wdata = 32'h0;
            mem_rdata = (i == 3) ? d : 32'hBAD0_BAD0;
            step();
            if (i == 0) begin
                chk("rd_issue_en", {31'b0, mem_en}, 32'd1);
                chk("rd_issue_addr", {16'b0, mem_addr}, {16'b0, a});
                chk("rd_issue_owner", {31'b0, owner}, 32'd0);
            end
            if (i == 1 || i == 2) chk("rd_early_ack", {31'b0, cpu_ack}, 32'd0);
            if (i == 3) begin
                chk("rd_ack", {31'b0, cpu_ack}, 32'd1);
                chk("rd_data", cpu_rdata, d);
            end
            if (i == 5) chk("rd_idle_busy", {31'b0, busy}, 32'd0);
        end
    endtask

    initial begin
        int nack;
        logic exp_ldr;

        // rst creq cwe caddr cwd | lreq lwe laddr lwd | mrd || cack lack crd lrd en we addr wd busy owner
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b1, 16'h0004, 32'h12345678, 32'h0,
                    1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0};
        tbl[1]  = tbl[0];
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b1, 16'h0004, 32'h12345678, 32'hBAD0BAD0,
                    1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b1, 16'h0004, 32'h12345678, 32'hBAD0BAD0,
                    1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0};
        tbl[4]  = tbl[3];
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b1, 16'h0004, 32'h12345678, 32'hDEADBEEF,
                    1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b0};
        // Core request still high in the ACK cycle must be ignored.
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 1'b1, 16'h0004, 32'h12345678, 32'hDEADBEEF,
                    1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 16'h0004, 32'h12345678, 32'hFFFFFFFF,
                    1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 1'b1, 1'b1, 16'h0004, 32'h12345678, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b1, 16'h0004, 32'h12345678, 32'hFFFFFFFF,
                    1'b0, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 32'hFFFFFFFF,
                    1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1};
        tbl[10] = tbl[9];

        for (int i = 0; i < 11; i++) begin
            apply(tbl[i]);
            step();
            chk($sformatf("row%0d_cpu_ack", i),   {31'b0, cpu_ack},   {31'b0, tbl[i].e_cack});
            chk($sformatf("row%0d_ldr_ack", i),   {31'b0, ldr_ack},   {31'b0, tbl[i].e_lack});
            chk($sformatf("row%0d_cpu_rdata", i), cpu_rdata,          tbl[i].e_crd);
            chk($sformatf("row%0d_ldr_rdata", i), ldr_rdata,          tbl[i].e_lrd);
            chk($sformatf("row%0d_mem_en", i),    {31'b0, mem_en},    {31'b0, tbl[i].e_en});
            chk($sformatf("row%0d_mem_we", i),    {31'b0, mem_we},    {31'b0, tbl[i].e_we});
            chk($sformatf("row%0d_mem_addr", i),  {16'b0, mem_addr},  {16'b0, tbl[i].e_addr});
            chk($sformatf("row%0d_mem_wdata", i), mem_wdata,          tbl[i].e_wd);
            chk($sformatf("row%0d_busy", i),      {31'b0, busy},      {31'b0, tbl[i].e_busy});
            chk($sformatf("row%0d_owner", i),     {31'b0, owner},     {31'b0, tbl[i].e_owner});
        end

        // Contention: both reading continuously from reset release.
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100; cpu_wdata = 32'h0;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0200; ldr_wdata = 32'h0;
        step();
        step();
        reset = 1'b0;
        nack = 0;
        for (int i = 0; i < 30 && nack < 4; i++) begin
            mem_rdata = 32'hC0DE_0000 | i;
            step();
            if (cpu_ack || ldr_ack) begin
                exp_ldr = nack[0];
                chk("cont_both_ack", {31'b0, cpu_ack & ldr_ack}, 32'd0);
                chk("cont_winner", {31'b0, ldr_ack}, {31'b0, exp_ldr});
                chk("cont_ack_cycle", i, 3 + 5 * nack);
                chk("cont_rdata", exp_ldr ? ldr_rdata : cpu_rdata, 32'hC0DE_0000 | i);
                nack++;
            end
        end
        chk("cont_ack_count", nack, 4);
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        step();
        step();

        // Late arrival: loader asks while the core read is waiting.
        for (int i = 0; i < 10; i++) begin
            cpu_req = (i < 4); cpu_addr = 16'h0030;
            ldr_req = (i >= 2 && i < 6); ldr_we = 1'b0; ldr_addr = 16'h0040;
            mem_rdata = 32'h1A7E_0000 | i;
            step();
            if (i == 0) chk("late_core_issue", {31'b0, mem_en}, 32'd1);
            if (i == 3) begin
                chk("late_cpu_ack", {31'b0, cpu_ack}, 32'd1);
                chk("late_cpu_rdata", cpu_rdata, 32'h1A7E_0003);
                chk("late_ldr_ack_quiet", {31'b0, ldr_ack}, 32'd0);
            end
            if (i == 4) chk("late_no_issue_in_idle", {31'b0, mem_en}, 32'd0);
            if (i == 5) begin
                chk("late_ldr_issue", {31'b0, mem_en}, 32'd1);
                chk("late_ldr_addr", {16'b0, mem_addr}, 32'h0040);
                chk("late_ldr_owner", {31'b0, owner}, 32'd1);
            end
            if (i == 8) begin
                chk("late_ldr_ack", {31'b0, ldr_ack}, 32'd1);
                chk("late_ldr_rdata", ldr_rdata, 32'h1A7E_0008);
                chk("late_cpu_rdata_kept", cpu_rdata, 32'h1A7E_0003);
            end
        end

        // Reset while the core read sits in WAIT.
        for (int i = 0; i < 9; i++) begin
            cpu_req = (i < 2); cpu_we = 1'b0; cpu_addr = 16'h0050;
            ldr_req = 1'b0;
            reset = (i == 2);
            mem_rdata = 32'h7777_0000 | i;
            step();
            if (i == 1) chk("rst_mid_busy_before", {31'b0, busy}, 32'd1);
            if (i >= 2) begin
                chk("rst_mid_no_ack", {31'b0, cpu_ack}, 32'd0);
                chk("rst_mid_rdata", cpu_rdata, 32'h0);
                chk("rst_mid_busy", {31'b0, busy}, 32'd0);
            end
        end
        core_read(16'h0020, 32'h600D_F00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
